// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B, one full-subtractor step per clock, LSB first.
// Operands are latched in IDLE, shifted through the cell in RUN, and held in DONE.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  // One extra count bit keeps WIDTH=1 legal (a zero-width counter otherwise).
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    count_q, count_d;

  logic x, y, d_bit, br_next;

  assign x       = sa_q[0];
  assign y       = sb_q[0];
  assign d_bit   = x ^ y ^ borrow_q;
  assign br_next = (~x & y) | (~(x ^ y) & borrow_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sa_d              = sa_q >> 1;
        sb_d              = sb_q >> 1;
        diff_d            = diff_q >> 1;
        diff_d[WIDTH-1]   = d_bit;
        borrow_d          = br_next;
        count_d           = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register, including
  // the datapath shift registers, is reset so diff is never X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8 and WIDTH=1: expected {bout,diff}
// is queued on accept and compared when out_valid appears.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, bo8, busy8;
  logic [7:0] a8, b8, d8;
  logic       iv1, ir1, ov1, or1, bo1, busy1;
  logic [0:0] a1, b1, d1;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .busy(busy8)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full-width subtraction gives the reference: low bits are diff, top bit is the borrow.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    full = {1'b0, a} - {1'b0, b};
    return full;
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [8:0] e;
    int lat;
    @(negedge clk);
    check("in_ready8_idle", ir8, 1);
    a8  = a;
    b8  = b;
    iv8 = 1'b1;
    or8 = (stall == 0);
    sb8.push_back(model8(a, b));
    @(posedge clk); #1;
    iv8 = 1'b0;
    check("busy8_after_accept", busy8, 1);
    lat = 0;
    while (!ov8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency8", lat, 8);
    if (!ov8) begin
      sb8.delete();
      return;
    end
    e = sb8.pop_front();
    check("diff8", d8, e[7:0]);
    check("bout8", bo8, e[8]);
    for (int i = 0; i < stall; i++) begin
      iv8 = 1'b1;
      a8  = 8'h12;
      b8  = 8'h34;
      @(posedge clk); #1;
      check("stall_out_valid8", ov8, 1);
      check("stall_in_ready8", ir8, 0);
      check("stall_diff8", d8, e[7:0]);
      check("stall_bout8", bo8, e[8]);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    check("idle_out_valid8", ov8, 0);
    check("idle_in_ready8", ir8, 1);
    or8 = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b);
    logic [1:0] e;
    logic [1:0] full;
    int lat;
    @(negedge clk);
    check("in_ready1_idle", ir1, 1);
    a1   = a;
    b1   = b;
    iv1  = 1'b1;
    or1  = 1'b1;
    full = {1'b0, a} - {1'b0, b};
    sb1.push_back(full);
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency1", lat, 1);
    if (!ov1) begin
      sb1.delete();
      return;
    end
    e = sb1.pop_front();
    check("diff1", d1, e[0]);
    check("bout1", bo1, e[1]);
    @(posedge clk); #1;
    check("idle_out_valid1", ov1, 0);
    or1 = 1'b0;
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_diff8", d8, 0);
    check("rst_bout8", bo8, 0);
    check("rst_in_ready1", ir1, 1);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'd100, 8'd37, 0);

    // Asynchronous reset pulse mid-cycle clears the held result immediately.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_diff8", d8, 0);
    check("async_rst_in_ready8", ir8, 1);
    check("async_rst_out_valid8", ov8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'd5, 8'd9, 0);
    op8(8'h00, 8'hFF, 0);
    op8(8'd200, 8'd201, 5);

    // Reset during the fourth RUN cycle: the operation must vanish.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy8", busy8, 0);
    check("midrun_rst_out_valid8", ov8, 0);
    check("midrun_rst_diff8", d8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov8) seen++;
    end
    check("midrun_no_output", seen, 0);
    or8 = 1'b0;

    op8(8'hAA, 8'h55, 0);
    op8(8'h7E, 8'h7E, 0);
    op8(8'hFF, 8'hFF, 0);
    op8(8'h00, 8'h00, 0);
    op8(8'hFF, 8'h00, 0);
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 6 == 0) ? ra : 8'($urandom_range(0, 255));
      op8(ra, rb, i % 3);
    end

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        op1(i[1], i[0]);
    for (int i = 0; i < 10; i++)
      op1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
